// File: rtl/seq_mult_ctrl_if.sv
// Operand/result bundle for the sequential multiplier: Start/Busy/Done handshake,
// operands and signed-mode flag in, product out.
interface seq_mult_ctrl_if #(
   parameter int WIDTH = 8
);
   logic               Start;
   logic               Signed;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic               Busy;
   logic               Done;
   logic [2*WIDTH-1:0] Product;

   modport master (
      output Start, Signed, A, B,
      input  Busy, Done, Product
   );

   modport slave (
      input  Start, Signed, A, B,
      output Busy, Done, Product
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier, unsigned or two's-complement, with a
// Start/Busy/Done handshake. Product is held until the next FIX state.
//
//  state | meaning
//  IDLE  | waiting for Start; operands captured on the edge that leaves
//  LOAD  | take operand magnitudes, result sign, clear Acc and Cnt
//  TEST  | inspect multiplier LSB
//  ADD   | Acc += multiplicand magnitude (carry kept in Acc MSB)
//  SHIFT | {Acc,Qreg} >>= 1, Cnt += 1; last bit goes to FIX
//  FIX   | apply sign to the magnitude product and latch Product
//  DONE  | one-cycle Done pulse, back to IDLE
module seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic           Clk,
   input  logic           Rst,
   seq_mult_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_TEST  = 3'd2,
      S_ADD   = 3'd3,
      S_SHIFT = 3'd4,
      S_FIX   = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sgn_q, sgn_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [2*WIDTH-1:0] mag_prod;
   logic [2*WIDTH:0]   shifted;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         m_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         neg_q   <= neg_d;
         m_q     <= m_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sgn_d    = sgn_q;
      neg_d    = neg_q;
      m_d      = m_q;
      q_d      = q_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      mag_prod = {acc_q[WIDTH-1:0], q_q};
      shifted  = {acc_q, q_q} >> 1;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               sgn_d   = bus.Signed;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
            m_d     = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
            q_d     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
            neg_d   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_TEST;
         end
         S_TEST: begin
            state_d = q_q[0] ? S_ADD : S_SHIFT;
         end
         S_ADD: begin
            acc_d   = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, m_q};
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            {acc_d, q_d} = shifted;
            cnt_d        = cnt_q + CNT_W'(1);
            state_d      = (cnt_q == CNT_LAST) ? S_FIX : S_TEST;
         end
         S_FIX: begin
            prod_d  = neg_q ? -mag_prod : mag_prod;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.Busy    = (state_q != S_IDLE);
   assign bus.Done    = (state_q == S_DONE);
   assign bus.Product = prod_q;

endmodule
